// File: rtl/shift_arbiter.sv
// Two-port round-robin front end for a shared external barrel rotator.
// Accepted requests are rotated for one cycle, then masked into
// SLL/SRL/SRA/ROR results and returned through a valid/ready port.
module shift_arbiter #(
    parameter int unsigned BitWidth = 32,
    parameter int unsigned AmtWidth = $clog2(BitWidth)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [1:0]          req0_op,
    input  logic [BitWidth-1:0] req0_data,
    input  logic [AmtWidth-1:0] req0_amount,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [1:0]          req1_op,
    input  logic [BitWidth-1:0] req1_data,
    input  logic [AmtWidth-1:0] req1_amount,
    output logic [BitWidth-1:0] rot_in,
    output logic [AmtWidth-1:0] rot_amount,
    output logic                rot_left1_right0,
    input  logic [BitWidth-1:0] rot_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [BitWidth-1:0] rsp_data
);

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b11;
    localparam logic [1:0] OpRor = 2'b10;

    localparam logic [BitWidth-1:0] Ones = '1;

    typedef enum logic [1:0] {StIdle, StRotate, StResp} state_e;

    state_e                state_q, state_d;
    logic                  rr_ptr_q;
    logic [1:0]            op_q;
    logic                  id_q;
    logic [BitWidth-1:0]   rot_in_q;
    logic [AmtWidth-1:0]   rot_amount_q;
    logic                  rot_left_q;
    logic                  rsp_id_q;
    logic [BitWidth-1:0]   rsp_data_q;

    logic                  accept;
    logic                  sel;
    logic [BitWidth-1:0]   lmask;
    logic [BitWidth-1:0]   rmask;
    logic [BitWidth-1:0]   result;

    // Grant: only in IDLE, ties broken by rr_ptr; readies held low during reset.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state_q == StIdle && !rst) begin
            req0_ready = req0_valid && (!req1_valid || rr_ptr_q == 1'b0);
            req1_ready = req1_valid && (!req0_valid || rr_ptr_q == 1'b1);
        end
        accept = req0_ready || req1_ready;
        sel    = req1_ready;
    end

    // Next-state: IDLE -> ROTATE on accept, ROTATE -> RESP, RESP -> IDLE on handshake.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StRotate;
            StRotate: state_d = StResp;
            StResp:   if (rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Mask the rotated word; sign fill for SRA comes from the latched operand MSB.
    always_comb begin
        lmask = Ones << rot_amount_q;
        rmask = Ones >> rot_amount_q;
        unique case (op_q)
            OpSll:   result = rot_out & lmask;
            OpSrl:   result = rot_out & rmask;
            OpSra:   result = (rot_out & rmask) | (rot_in_q[BitWidth-1] ? ~rmask : '0);
            OpRor:   result = rot_out;
            default: result = rot_out;
        endcase
    end

    // State, operand latches on accept and result capture at the end of ROTATE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rr_ptr_q     <= 1'b0;
            op_q         <= OpSll;
            id_q         <= 1'b0;
            rot_in_q     <= '0;
            rot_amount_q <= '0;
            rot_left_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                // Point at the port that was not just served.
                rr_ptr_q     <= ~sel;
                id_q         <= sel;
                op_q         <= sel ? req1_op : req0_op;
                rot_in_q     <= sel ? req1_data : req0_data;
                rot_amount_q <= sel ? req1_amount : req0_amount;
                rot_left_q   <= ((sel ? req1_op : req0_op) == OpSll);
            end
            if (state_q == StRotate) begin
                rsp_data_q <= result;
                rsp_id_q   <= id_q;
            end
        end
    end

    assign rot_in           = rot_in_q;
    assign rot_amount       = rot_amount_q;
    assign rot_left1_right0 = rot_left_q;
    assign rsp_valid        = (state_q == StResp);
    assign rsp_id           = rsp_id_q;
    assign rsp_data         = rsp_data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed scoreboard bench for shift_arbiter with a behavioural rotator.
module tb_shift_arbiter;

    localparam int W = 32;
    localparam int A = 5;

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b11;
    localparam logic [1:0] OpRor = 2'b10;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_data, req1_data;
    logic [A-1:0] req0_amount, req1_amount;
    logic [W-1:0] rot_in, rot_out, rsp_data;
    logic [A-1:0] rot_amount;
    logic         rot_left1_right0;
    logic         rsp_valid, rsp_ready, rsp_id;

    typedef struct packed {
        logic         id;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    shift_arbiter #(.BitWidth(W), .AmtWidth(A)) dut (
        .clk              (clk),
        .rst              (rst),
        .req0_valid       (req0_valid),
        .req0_ready       (req0_ready),
        .req0_op          (req0_op),
        .req0_data        (req0_data),
        .req0_amount      (req0_amount),
        .req1_valid       (req1_valid),
        .req1_ready       (req1_ready),
        .req1_op          (req1_op),
        .req1_data        (req1_data),
        .req1_amount      (req1_amount),
        .rot_in           (rot_in),
        .rot_amount       (rot_amount),
        .rot_left1_right0 (rot_left1_right0),
        .rot_out          (rot_out),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_id           (rsp_id),
        .rsp_data         (rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rotate(input logic [W-1:0] d, input logic [A-1:0] n,
                                            input logic left);
        int s;
        s = int'(n);
        if (s == 0) return d;
        if (left) return (d << s) | (d >> (W - s));
        return (d >> s) | (d << (W - s));
    endfunction

    // External rotator model.
    always_comb rot_out = rotate(rot_in, rot_amount, rot_left1_right0);

    function automatic logic [W-1:0] golden(input logic [1:0] op, input logic [W-1:0] d,
                                            input logic [A-1:0] n);
        int s;
        s = int'(n);
        case (op)
            OpSll:   return d << s;
            OpSrl:   return d >> s;
            OpSra:   return $unsigned($signed(d) >>> s);
            default: return (s == 0) ? d : ((d >> s) | (d << (W - s)));
        endcase
    endfunction

    function automatic logic [1:0] c_op(input int p, input int i);
        logic [1:0] r;
        r = 2'((i + p) % 4);
        return r;
    endfunction

    function automatic logic [W-1:0] c_data(input int p, input int i);
        return (p == 1) ? (32'hC001_0000 + 32'(i * 32'h111)) : (32'h0000_00F1 << i);
    endfunction

    function automatic logic [A-1:0] c_amt(input int p, input int i);
        return A'(i * 3 + 1 + p);
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic [1:0] op,
                            input logic [W-1:0] d, input logic [A-1:0] n);
        if (p == 0) begin
            req0_valid = v; req0_op = op; req0_data = d; req0_amount = n;
        end else begin
            req1_valid = v; req1_op = op; req1_data = d; req1_amount = n;
        end
    endtask

    task automatic push(input int p, input logic [1:0] op, input logic [W-1:0] d,
                        input logic [A-1:0] n);
        exp_t e;
        e.id   = (p == 1);
        e.data = golden(op, d, n);
        sb.push_back(e);
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"}, rsp_data, e.data);
            chk({tag, "_id"}, 32'(rsp_id), 32'(e.id));
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input int p, input logic [1:0] op, input logic [W-1:0] d,
                         input logic [A-1:0] n, input bit track);
        int k;
        k = 0;
        set_port(p, 1'b1, op, d, n);
        #1;
        while (!((p == 1) ? req1_ready : req0_ready) && k < 20) begin
            @(negedge clk); #1; k++;
        end
        if (k >= 20) chk("accept_timeout", 32'(k), 32'd0);
        if (track) push(p, op, d, n);
        @(posedge clk);
        @(negedge clk);
        set_port(p, 1'b0, op, d, n);
    endtask

    // Wait for a response (rsp_ready assumed high), check latency and scoreboard.
    task automatic wait_rsp(input string tag, input bit check_lat);
        int lat;
        lat = 1;
        #1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        if (check_lat) chk({tag, "_latency"}, 32'(lat), 32'd2);
        check_pop(tag);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx[2];
        int   grants, exp_g, g, cyc, k;
        exp_t e;

        rst = 1'b1;
        rsp_ready = 1'b1;
        idx[0] = 0;
        idx[1] = 0;
        // Both ports contend from reset.
        set_port(0, 1'b1, c_op(0, 0), c_data(0, 0), c_amt(0, 0));
        set_port(1, 1'b1, c_op(1, 0), c_data(1, 0), c_amt(1, 0));

        @(negedge clk);
        @(negedge clk); #1;
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rot_in", rot_in, 32'd0);
        chk("rst_rot_amount", 32'(rot_amount), 32'd0);
        chk("rst_rot_dir", 32'(rot_left1_right0), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Contention: grants alternate 0,1,0,1 and responses follow grant order.
        grants = 0; exp_g = 0; cyc = 0;
        while (cyc < 40 && (grants < 4 || sb.size() != 0)) begin
            #1;
            chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
            if (rsp_valid) check_pop("contend");
            g = -1;
            if (req0_ready) g = 0;
            else if (req1_ready) g = 1;
            if (g >= 0) begin
                chk("grant_order", 32'(g), 32'(exp_g));
                push(g, c_op(g, idx[g]), c_data(g, idx[g]), c_amt(g, idx[g]));
                exp_g = 1 - exp_g;
                grants++;
            end
            @(negedge clk);
            if (g >= 0) begin
                idx[g]++;
                set_port(g, 1'b1, c_op(g, idx[g]), c_data(g, idx[g]), c_amt(g, idx[g]));
            end
            if (grants >= 4) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            cyc++;
        end
        chk("contend_grants", 32'(grants), 32'd4);
        @(negedge clk);

        // SLL / SRL / SRA / ROR directed vectors.
        issue(0, OpSll, 32'h8000_0001, 5'd1, 1'b1);  wait_rsp("sll1", 1'b1);
        issue(0, OpSrl, 32'h8000_0000, 5'd4, 1'b1);  wait_rsp("srl4", 1'b1);
        issue(1, OpSra, 32'h8000_0000, 5'd4, 1'b1);  wait_rsp("sra4_neg", 1'b1);
        issue(1, OpSra, 32'h4000_0000, 5'd4, 1'b1);  wait_rsp("sra4_pos", 1'b1);
        issue(0, OpRor, 32'h0000_0001, 5'd1, 1'b1);  wait_rsp("ror1", 1'b1);
        for (int op = 0; op < 4; op++) begin
            issue(op % 2, 2'(op), 32'hDEAD_BEEF, 5'd0, 1'b1);
            wait_rsp("amt0", 1'b1);
        end
        issue(0, OpSll, 32'hFFFF_FFFF, 5'd31, 1'b1); wait_rsp("sll31", 1'b1);
        issue(1, OpSra, 32'h8000_0000, 5'd31, 1'b1); wait_rsp("sra31", 1'b1);
        issue(0, OpSrl, 32'hFFFF_FFFF, 5'd31, 1'b1); wait_rsp("srl31", 1'b1);
        issue(1, OpRor, 32'h1234_5678, 5'd31, 1'b1); wait_rsp("ror31", 1'b1);

        // Backpressure: response held stable, readies low while a request waits.
        rsp_ready = 1'b0;
        issue(0, OpSrl, 32'h1234_5678, 5'd8, 1'b1);
        set_port(1, 1'b1, OpRor, 32'hA5A5_0F0F, 5'd12);
        k = 1;
        #1;
        while (!rsp_valid && k < 20) begin
            @(negedge clk); #1; k++;
        end
        chk("bp_latency", 32'(k), 32'd2);
        e = '0;
        if (sb.size() != 0) e = sb.pop_front();
        else chk("bp_sb_empty", 32'(sb.size()), 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", rsp_data, e.data);
            chk("bp_id", 32'(rsp_id), 32'(e.id));
            chk("bp_ready0", 32'(req0_ready), 32'd0);
            chk("bp_ready1", 32'(req1_ready), 32'd0);
            @(negedge clk); #1;
        end
        chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        push(1, OpRor, 32'hA5A5_0F0F, 5'd12);
        @(negedge clk); #1;
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_next_accept", 32'(req1_ready), 32'd1);
        @(negedge clk);
        set_port(1, 1'b0, OpRor, 32'hA5A5_0F0F, 5'd12);
        wait_rsp("bp_next", 1'b1);

        // Reset during ROTATE discards the operation and restores rr_ptr = 0.
        issue(0, OpSll, 32'hF0F0_F0F0, 5'd3, 1'b0);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rsp_data", rsp_data, 32'd0);
        chk("mid_rsp_id", 32'(rsp_id), 32'd0);
        chk("mid_rot_in", rot_in, 32'd0);
        chk("mid_rot_amount", 32'(rot_amount), 32'd0);
        chk("mid_rot_dir", 32'(rot_left1_right0), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk("mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        set_port(0, 1'b1, OpSra, 32'h8765_4321, 5'd7);
        set_port(1, 1'b1, OpSll, 32'h0000_0F0F, 5'd2);
        #1;
        chk("post_rst_ready0", 32'(req0_ready), 32'd1);
        chk("post_rst_ready1", 32'(req1_ready), 32'd0);
        push(0, OpSra, 32'h8765_4321, 5'd7);
        req1_valid = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        wait_rsp("post_rst", 1'b1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
